// File: rtl/truth_table_sweep_if.sv
// Sweep controller bundle: start/response inputs, vector drive, status and result outputs.
// maxterms exists only when TT_SWEEP_MAXTERM_EN is defined.
interface truth_table_sweep_if;
    logic        start;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic [3:0]  s_in;
    logic        busy;
    logic        done;
    logic [15:0] minterms;
    logic        mismatch;
    logic [3:0]  mismatch_idx;
`ifdef TT_SWEEP_MAXTERM_EN
    logic [15:0] maxterms;
`endif

`ifdef TT_SWEEP_MAXTERM_EN
    modport master (
        output start, s_in,
        input  a, b, c, d, busy, done, minterms, mismatch, mismatch_idx, maxterms
    );
    modport slave (
        input  start, s_in,
        output a, b, c, d, busy, done, minterms, mismatch, mismatch_idx, maxterms
    );
`else
    modport master (
        output start, s_in,
        input  a, b, c, d, busy, done, minterms, mismatch, mismatch_idx
    );
    modport slave (
        input  start, s_in,
        output a, b, c, d, busy, done, minterms, mismatch, mismatch_idx
    );
`endif
endinterface

// File: rtl/truth_table_sweep.sv
// Walks all 16 {a,b,c,d} vectors (settle cycle + sample cycle each), records SoP canonical response
// and flags the first vector where the four implementations disagree. Optional maxterms: TT_SWEEP_MAXTERM_EN.
module truth_table_sweep (
    input  logic                 clk,
    input  logic                 reset,
    truth_table_sweep_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  idx_d;
    logic [3:0]  vec_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] minterms_q;
    logic        mismatch_q;
    logic [3:0]  mismatch_idx_q;
    logic        vec_mis_d;
`ifdef TT_SWEEP_MAXTERM_EN
    logic [15:0] maxterms_q;
`endif

    always_comb begin
        idx_d     = idx_q + 4'd1;
        // The four implementations agree only if the response is all-zero or all-one.
        vec_mis_d = (bus.s_in != 4'h0) && (bus.s_in != 4'hF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= 4'd0;
            vec_q          <= 4'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            minterms_q     <= 16'h0000;
            mismatch_q     <= 1'b0;
            mismatch_idx_q <= 4'd0;
`ifdef TT_SWEEP_MAXTERM_EN
            maxterms_q     <= 16'h0000;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q        <= DRIVE;
                        idx_q          <= 4'd0;
                        vec_q          <= 4'd0;
                        busy_q         <= 1'b1;
                        minterms_q     <= 16'h0000;
                        mismatch_q     <= 1'b0;
                        mismatch_idx_q <= 4'd0;
`ifdef TT_SWEEP_MAXTERM_EN
                        maxterms_q     <= 16'h0000;
`endif
                    end
                end
                DRIVE: begin
                    state_q <= SAMPLE;
                end
                SAMPLE: begin
                    minterms_q[idx_q] <= bus.s_in[0];
`ifdef TT_SWEEP_MAXTERM_EN
                    maxterms_q[idx_q] <= ~bus.s_in[2];
`endif
                    if (vec_mis_d && !mismatch_q) begin
                        mismatch_q     <= 1'b1;
                        mismatch_idx_q <= idx_q;
                    end
                    // Last vector ends the sweep rather than letting the index wrap.
                    if (idx_q == 4'hF) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        vec_q   <= 4'd0;
                    end else begin
                        state_q <= DRIVE;
                        idx_q   <= idx_d;
                        vec_q   <= idx_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {bus.a, bus.b, bus.c, bus.d} = vec_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.minterms     = minterms_q;
    assign bus.mismatch     = mismatch_q;
    assign bus.mismatch_idx = mismatch_idx_q;
`ifdef TT_SWEEP_MAXTERM_EN
    assign bus.maxterms     = maxterms_q;
`endif
endmodule

// File: tb/tb_truth_table_sweep.sv
// Random and directed sweeps of truth_table_sweep against a table-based reference model.
module tb_truth_table_sweep;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    // Response tables: bit i of f_k is s_in[k] while vector i is driven.
    logic [15:0] f0, f1, f2, f3;

    truth_table_sweep_if bus ();

    truth_table_sweep dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        logic [3:0] v;
        v = {bus.a, bus.b, bus.c, bus.d};
        bus.s_in = {f3[v], f2[v], f1[v], f0[v]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_func(input logic [15:0] f, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
        f0 = f;
        f1 = f ^ e1;
        f2 = f ^ e2;
        f3 = f ^ e3;
    endtask

    // Expected results derived straight from the tables.
    task automatic check_results(input string tag);
        logic       found;
        logic [3:0] first;
        logic [3:0] bits;
        found = 1'b0;
        first = 4'd0;
        for (int i = 0; i < 16; i++) begin
            bits = {f3[i], f2[i], f1[i], f0[i]};
            if (!found && bits != 4'h0 && bits != 4'hF) begin
                found = 1'b1;
                first = 4'(i);
            end
        end
        chk({tag, ".minterms"}, 32'(bus.minterms), 32'(f0));
        chk({tag, ".mismatch"}, 32'(bus.mismatch), 32'(found));
        chk({tag, ".mis_idx"}, 32'(bus.mismatch_idx), 32'(first));
`ifdef TT_SWEEP_MAXTERM_EN
        chk({tag, ".maxterms"}, 32'(bus.maxterms), 32'(~f2));
`endif
    endtask

    // Pulses start, follows the sweep cycle by cycle and checks timing/vectors.
    // inject_at >= 0 re-asserts start that many cycles after the start edge.
    task automatic run_sweep(input string tag, input int inject_at);
        int lat;
        int vec_err;
        int busy_err;
        lat      = -1;
        vec_err  = 0;
        busy_err = 0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int n = 0; n < 40 && lat < 0; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            bus.start = (n == inject_at);
            if (bus.done) begin
                lat = n;
            end else begin
                if (int'({bus.a, bus.b, bus.c, bus.d}) != (n >> 1)) vec_err++;
                if (!bus.busy) busy_err++;
            end
        end
        bus.start = 1'b0;
        chk({tag, ".latency"}, 32'(lat), 32'd32);
        chk({tag, ".vec_seq_errs"}, 32'(vec_err), 32'd0);
        chk({tag, ".busy_errs"}, 32'(busy_err), 32'd0);
        chk({tag, ".busy_in_done"}, 32'(bus.busy), 32'd0);
        chk({tag, ".abcd_in_done"}, 32'({bus.a, bus.b, bus.c, bus.d}), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, ".done_one_cycle"}, 32'(bus.done), 32'd0);
        check_results(tag);
    endtask

    initial begin
        logic [15:0] r1, r2, r3;
        int dones;
        total     = 0;
        bad       = 0;
        bus.start = 1'b0;
        set_func(16'h5363, 16'h0, 16'h0, 16'h0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.minterms", 32'(bus.minterms), 32'd0);
        chk("rst.mismatch", 32'(bus.mismatch), 32'd0);
        chk("rst.mis_idx", 32'(bus.mismatch_idx), 32'd0);
        chk("rst.abcd", 32'({bus.a, bus.b, bus.c, bus.d}), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Consistent implementations of the reference function.
        run_sweep("clean", -1);

        // Results hold in IDLE; start held low.
        repeat (5) @(posedge clk);
        #1;
        chk("hold.minterms", 32'(bus.minterms), 32'h5363);

        // SoP simplified wrong at vectors 3 and 10.
        set_func(16'h5363, 16'h0408, 16'h0, 16'h0);
        run_sweep("err3_10", -1);

        // Start during a sweep is ignored.
        set_func(16'h5363, 16'h0, 16'h0, 16'h0);
        run_sweep("restart_ign", 5);

        // A fresh start from IDLE clears results on its edge.
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("clr.minterms", 32'(bus.minterms), 32'd0);
        chk("clr.busy", 32'(bus.busy), 32'd1);

        // Reset at cycle 10 of that sweep.
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst.busy", 32'(bus.busy), 32'd0);
        chk("midrst.minterms", 32'(bus.minterms), 32'd0);
        chk("midrst.abcd", 32'({bus.a, bus.b, bus.c, bus.d}), 32'd0);
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("midrst.no_done", 32'(dones), 32'd0);

        // Random functions with sparse disagreements.
        for (int t = 0; t < 6; t++) begin
            r1 = 16'($urandom) & 16'($urandom) & 16'($urandom);
            r2 = 16'($urandom) & 16'($urandom) & 16'($urandom);
            r3 = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if (t == 0) begin
                r1 = 16'h0;
                r2 = 16'h0;
                r3 = 16'h0;
            end
            set_func(16'($urandom), r1, r2, r3);
            run_sweep($sformatf("rnd%0d", t), (t == 3) ? int'($urandom_range(1, 30)) : -1);
            repeat (int'($urandom_range(0, 3))) @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/truth_table_sweep.md
TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset; the ports are listed below with clock and reset first.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a 16-vector sweep.
REQ-005 a, b, c, d  output  1 each  stimulus vector driven to the four implementations under test; a is the MSB, d the LSB.
REQ-006 s_in  input  4  responses: s_in[0] SoP canonical, s_in[1] SoP simplified, s_in[2] PoS canonical, s_in[3] PoS simplified.
REQ-007 busy  output  1  high while a sweep is in progress.
REQ-008 done  output  1  one-cycle pulse when a sweep completes.
REQ-009 minterms  output  16  bit i = sampled s_in[0] for vector i = {a,b,c,d}.
REQ-010 mismatch  output  1  sticky flag: at least one vector had s_in bits that were not all equal.
REQ-011 mismatch_idx  output  4  index of the first mismatching vector; 0 when mismatch=0.

Function
REQ-012 The FSM SHALL have four states: IDLE, DRIVE, SAMPLE and DONE.
REQ-013 IDLE: busy=0. If start=1, the FSM goes to DRIVE, the vector index is set to 0, and minterms, mismatch and mismatch_idx are cleared in the same edge.
REQ-014 DRIVE: {a,b,c,d} = index and busy=1; the FSM goes to SAMPLE on the next edge (one settle cycle).
REQ-015 SAMPLE: {a,b,c,d} is held; on the edge, s_in[0] is written into minterms[index] and the mismatch check is applied.
REQ-016 Mismatch check: if the s_in bits are not all equal and mismatch=0, the block sets mismatch=1 and mismatch_idx=index; later mismatches do not change mismatch_idx.
REQ-017 SAMPLE exit: if index=15, the FSM goes to DONE; otherwise index increments by 1 and the FSM returns to DRIVE. The index is 4 bits and SHALL NOT wrap into a 17th vector.
REQ-018 DONE: done=1 and busy=0 for exactly one cycle, then the FSM goes to IDLE.
REQ-019 Sweep latency: 32 cycles from the start edge to the DONE cycle, giving the done pulse in cycle 33.
REQ-020 start while busy or in DONE SHALL be ignored, with no restart and no clearing of results.
REQ-021 Results: minterms, mismatch and mismatch_idx hold their values in IDLE until the next accepted start.
REQ-022 Outside DRIVE and SAMPLE, {a,b,c,d} SHALL be 0000.

Reset
REQ-023 While reset=1, the FSM goes to IDLE, index=0, a=b=c=d=0, busy=0, done=0, minterms=0, mismatch=0 and mismatch_idx=0.
REQ-024 Reset SHALL take priority over start and over any in-flight sweep. A reset mid-sweep discards partial results and produces no done pulse.

Configuration
REQ-025 Macro TT_SWEEP_MAXTERM_EN: when defined, the block SHALL add an output maxterms (16 bits) where bit i = NOT(sampled s_in[2]) for vector i. This output is cleared on start and reset and held like minterms.
REQ-026 Without TT_SWEEP_MAXTERM_EN, the maxterms port and its register SHALL be absent, and all other behaviour is unchanged.

Verification
REQ-027 Reset then start, with all four s_in bits driven from the function with ones at vectors 0,1,5,6,8,9,12,14 -> minterms=16'h5363, mismatch=0, done pulse 32 cycles after the start edge.
REQ-028 Same as REQ-027 with TT_SWEEP_MAXTERM_EN defined -> maxterms=16'hAC9C.
REQ-029 Same function, but s_in[1] forced to 1 at vectors 3 and 10 -> mismatch=1, mismatch_idx=4'd3, minterms=16'h5363.
REQ-030 Assert reset at cycle 10 of a sweep -> busy=0, minterms=0 and a..d=0 on the next cycle, and no done pulse follows.
REQ-031 Pulse start again at cycle 5 of a sweep -> ignored, with done still occurring 32 cycles after the first start. A subsequent start from IDLE clears minterms to 0 on its edge.
